// File: rtl/div_ctrl_pkg.sv
// div_ctrl_pkg: shared FSM encoding, datapath width and iteration constants for div_ctrl.
package div_ctrl_pkg;
    localparam int DIV_XLEN  = 64;
    localparam int DIV_ITERS = 64;
    localparam int DIV_CNT_W = $clog2(DIV_ITERS);
    localparam logic [DIV_CNT_W-1:0] DIV_CNT_INIT = DIV_CNT_W'(DIV_ITERS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREP,
        ST_ITER,
        ST_FIX,
        ST_DONE
    } div_state_e;

    function automatic logic [DIV_XLEN-1:0] cond_neg(input logic [DIV_XLEN-1:0] x, input logic en);
        return en ? -x : x;
    endfunction
endpackage

// File: rtl/div_ctrl_adder.sv
// div_ctrl_adder: W-bit adder; control=1 subtracts b from a in two's complement.
module div_ctrl_adder #(
    parameter int W = 66
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         control,
    output logic [W-1:0] sum
);
    assign sum = a + (b ^ {W{control}}) + W'(control);
endmodule

// File: rtl/div_ctrl.sv
// div_ctrl: 64-bit restoring divider, one quotient bit per cycle; DIV_ZERO_FAST_EN short-cuts divide-by-zero.
module div_ctrl
    import div_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DIV_XLEN-1:0] src1,
    input  logic [DIV_XLEN-1:0] src2,
    input  logic                is_signed,
    input  logic                is_rem,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DIV_XLEN-1:0] result,
    output logic                busy
);
    div_state_e           state_q, state_d;
    logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
    logic [DIV_XLEN-1:0]  quo_q, quo_d;
    logic [DIV_XLEN:0]    rem_q, rem_d;
    logic [DIV_XLEN-1:0]  div_q, div_d;
    logic [DIV_XLEN-1:0]  res_q, res_d;
    logic                 is_signed_q, is_signed_d;
    logic                 is_rem_q, is_rem_d;
    logic                 sign_q_q, sign_q_d;
    logic                 sign_r_q, sign_r_d;
    logic [DIV_XLEN+1:0]  shifted, trial;
    logic                 borrow;

    // Two guard bits: the shifted partial remainder can exceed 64 bits, and the top bit flags a borrow.
    assign shifted = {rem_q, quo_q[DIV_XLEN-1]};
    assign borrow  = trial[DIV_XLEN+1];

    div_ctrl_adder #(.W(DIV_XLEN + 2)) u_sub (
        .a       (shifted),
        .b       ({2'b00, div_q}),
        .control (1'b1),
        .sum     (trial)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        quo_d       = quo_q;
        rem_d       = rem_q;
        div_d       = div_q;
        res_d       = res_q;
        is_signed_d = is_signed_q;
        is_rem_d    = is_rem_q;
        sign_q_d    = sign_q_q;
        sign_r_d    = sign_r_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    quo_d       = src1;
                    div_d       = src2;
                    is_signed_d = is_signed;
                    is_rem_d    = is_rem;
                    state_d     = ST_PREP;
`ifdef DIV_ZERO_FAST_EN
                    if (src2 == '0) begin
                        res_d   = is_rem ? src1 : '1;
                        state_d = ST_DONE;
                    end
`endif
                end
            end
            ST_PREP: begin
                quo_d    = cond_neg(quo_q, is_signed_q && quo_q[DIV_XLEN-1]);
                div_d    = cond_neg(div_q, is_signed_q && div_q[DIV_XLEN-1]);
                rem_d    = '0;
                sign_q_d = quo_q[DIV_XLEN-1] ^ div_q[DIV_XLEN-1];
                sign_r_d = quo_q[DIV_XLEN-1];
                cnt_d    = DIV_CNT_INIT;
                state_d  = ST_ITER;
            end
            ST_ITER: begin
                quo_d   = {quo_q[DIV_XLEN-2:0], ~borrow};
                rem_d   = borrow ? shifted[DIV_XLEN:0] : trial[DIV_XLEN:0];
                cnt_d   = cnt_q - DIV_CNT_W'(1);
                state_d = (cnt_q == '0) ? ST_FIX : ST_ITER;
            end
            ST_FIX: begin
                res_d   = is_rem_q ? cond_neg(rem_q[DIV_XLEN-1:0], is_signed_q && sign_r_q)
                                   : cond_neg(quo_q, is_signed_q && sign_q_q && (div_q != '0));
                state_d = ST_DONE;
            end
            ST_DONE: state_d = out_ready ? ST_IDLE : ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            div_q       <= '0;
            res_q       <= '0;
            is_signed_q <= 1'b0;
            is_rem_q    <= 1'b0;
            sign_q_q    <= 1'b0;
            sign_r_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            quo_q       <= quo_d;
            rem_q       <= rem_d;
            div_q       <= div_d;
            res_q       <= res_d;
            is_signed_q <= is_signed_d;
            is_rem_q    <= is_rem_d;
            sign_q_q    <= sign_q_d;
            sign_r_q    <= sign_r_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = res_q;
endmodule
